branch_target_buffer: RTL and testbench



---
 rtl/branch_target_buffer_pkg.sv | 24 ++
 rtl/branch_target_buffer_ctr_next.sv | 33 +++
 rtl/branch_target_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: default widths, the
// controller state encoding and the direction-counter constants.
package branch_target_buffer_pkg;

    localparam int BTB_DBITS    = 32;
    localparam int BTB_INSTSIZE = 4;

    // Controller state: INIT sweeps the tables, READY serves lookups/updates.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } btb_state_e;

    // Weakly not-taken counter value for a cntbits-wide counter.
    function automatic int ctr_wnt(input int cntbits);
        return (32'sd1 <<< (cntbits - 1)) - 32'sd1;
    endfunction

    // Weakly taken counter value for a cntbits-wide counter.
    function automatic int ctr_wt(input int cntbits);
        return 32'sd1 <<< (cntbits - 1);
    endfunction

endpackage

// File: rtl/branch_target_buffer_ctr_next.sv
// Saturating up/down direction counter: next value from current value and
// the resolved branch direction.
module btb_ctr_next #(
    parameter int CNTBITS = 2
) (
    input  logic [CNTBITS-1:0] ctr,
    input  logic               taken,
    output logic [CNTBITS-1:0] ctr_next
);

    localparam logic [CNTBITS-1:0] CTR_MAX = {CNTBITS{1'b1}};
    localparam logic [CNTBITS-1:0] CTR_MIN = {CNTBITS{1'b0}};
    localparam logic [CNTBITS-1:0] CTR_ONE = CNTBITS'(1);

    // Step towards taken/not-taken, holding at either end of the range.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr == CTR_MAX) begin
                ctr_next = ctr;
            end else begin
                ctr_next = ctr + CTR_ONE;
            end
        end else begin
            if (ctr == CTR_MIN) begin
                ctr_next = ctr;
            end else begin
                ctr_next = ctr - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Tagged branch target buffer with saturating-counter direction prediction.
// Fetch looks up the current PC combinationally; the M stage writes back
// resolved branches; a sequential sweep clears the tables after reset/flush.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int DBITS    = BTB_DBITS,
    parameter int INSTSIZE = BTB_INSTSIZE,
    parameter int IDXBITS  = 8,
    parameter int TAGBITS  = 8,
    parameter int CNTBITS  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] lookup_pc,
    output logic [DBITS-1:0] pred_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [DBITS-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target,
    input  logic             flush,
    output logic             ready
);

    localparam int                 NENT       = 1 << IDXBITS;
    localparam int                 PCHI       = IDXBITS + TAGBITS + 2;
    localparam logic [IDXBITS-1:0] SWEEP_LAST = {IDXBITS{1'b1}};
    localparam logic [IDXBITS-1:0] IDX_ZERO   = {IDXBITS{1'b0}};
    localparam logic [IDXBITS-1:0] IDX_ONE    = IDXBITS'(1);
    localparam logic [CNTBITS-1:0] CTR_WNT    = CNTBITS'(ctr_wnt(CNTBITS));
    localparam logic [CNTBITS-1:0] CTR_WT     = CNTBITS'(ctr_wt(CNTBITS));
    localparam logic [DBITS-1:0]   PC_STEP    = DBITS'(INSTSIZE);

    // Controller state
    btb_state_e         state_q, state_d;
    logic [IDXBITS-1:0] sweep_idx_q, sweep_idx_d;
    logic               ready_q, ready_d;

    // Tables: valid bits kept apart from tag/target/counter storage
    logic               valid_q  [NENT];
    logic [TAGBITS-1:0] tag_q    [NENT];
    logic [DBITS-1:0]   target_q [NENT];
    logic [CNTBITS-1:0] ctr_q    [NENT];

    // Single write port shared by the sweep and the M-stage update
    logic [IDXBITS-1:0] wr_idx_s;
    logic               valid_we_s;
    logic               valid_wdata_s;
    logic               tag_we_s;
    logic [TAGBITS-1:0] tag_wdata_s;
    logic               target_we_s;
    logic [DBITS-1:0]   target_wdata_s;
    logic               ctr_we_s;
    logic [CNTBITS-1:0] ctr_wdata_s;

    // Lookup and update decode
    logic [IDXBITS-1:0] lk_idx_s;
    logic [TAGBITS-1:0] lk_tag_s;
    logic               lk_hit_s;
    logic               lk_taken_s;
    logic [DBITS-1:0]   lk_pc_s;
    logic [IDXBITS-1:0] up_idx_s;
    logic [TAGBITS-1:0] up_tag_s;
    logic               up_hit_s;
    logic               up_ok_s;
    logic [CNTBITS-1:0] up_ctr_s;
    logic [CNTBITS-1:0] up_ctr_next_s;

    assign lk_idx_s = lookup_pc[IDXBITS+1:2];
    assign lk_tag_s = lookup_pc[PCHI-1:IDXBITS+2];
    assign up_idx_s = upd_pc[IDXBITS+1:2];
    assign up_tag_s = upd_pc[PCHI-1:IDXBITS+2];

    // Only the index and tag fields of the update PC address the tables.
    logic unused_upd_s;
    generate
        if (PCHI < DBITS) begin : g_upd_hi
            assign unused_upd_s = ^{upd_pc[DBITS-1:PCHI], upd_pc[1:0]};
        end else begin : g_upd_nohi
            assign unused_upd_s = ^upd_pc[1:0];
        end
    endgenerate

    btb_ctr_next #(
        .CNTBITS (CNTBITS)
    ) u_ctr_next (
        .ctr      (up_ctr_s),
        .taken    (upd_taken),
        .ctr_next (up_ctr_next_s)
    );

    // Controller state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= IDX_ZERO;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state logic: flush restarts the sweep, the last entry ends it.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (flush) begin
            state_d     = ST_INIT;
            sweep_idx_d = IDX_ZERO;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (sweep_idx_q == SWEEP_LAST) begin
                        state_d     = ST_READY;
                        sweep_idx_d = IDX_ZERO;
                    end else begin
                        state_d     = ST_INIT;
                        sweep_idx_d = sweep_idx_q + IDX_ONE;
                    end
                end
                ST_READY: begin
                    state_d     = ST_READY;
                    sweep_idx_d = sweep_idx_q;
                end
                default: begin
                    state_d     = ST_INIT;
                    sweep_idx_d = IDX_ZERO;
                end
            endcase
        end
        // ready is a registered decode of the next state, so it rises on
        // the same edge that clears the last entry.
        ready_d = (state_d == ST_READY);
    end

    // Output logic: table write controls from the sweep or the M-stage update.
    always_comb begin
        up_ctr_s       = ctr_q[up_idx_s];
        up_hit_s       = valid_q[up_idx_s] & (tag_q[up_idx_s] == up_tag_s);
        up_ok_s        = upd_valid & ready_q & ~flush & ~reset;
        wr_idx_s       = up_idx_s;
        valid_we_s     = 1'b0;
        valid_wdata_s  = 1'b0;
        tag_we_s       = 1'b0;
        tag_wdata_s    = up_tag_s;
        target_we_s    = 1'b0;
        target_wdata_s = upd_target;
        ctr_we_s       = 1'b0;
        ctr_wdata_s    = up_ctr_next_s;
        if (reset) begin
            valid_we_s = 1'b0;
        end else if (state_q == ST_INIT) begin
            // Sweep: invalidate and park the counter at weakly not-taken.
            wr_idx_s      = sweep_idx_q;
            valid_we_s    = 1'b1;
            valid_wdata_s = 1'b0;
            ctr_we_s      = 1'b1;
            ctr_wdata_s   = CTR_WNT;
        end else if (up_ok_s) begin
            if (up_hit_s) begin
                // Train the counter; only a taken outcome refreshes the target.
                ctr_we_s    = 1'b1;
                ctr_wdata_s = up_ctr_next_s;
                target_we_s = upd_taken;
            end else if (upd_taken) begin
                // Allocate over whatever aliases this index.
                valid_we_s    = 1'b1;
                valid_wdata_s = 1'b1;
                tag_we_s      = 1'b1;
                target_we_s   = 1'b1;
                ctr_we_s      = 1'b1;
                ctr_wdata_s   = CTR_WT;
            end else begin
                // A not-taken miss carries no information worth storing.
                ctr_we_s = 1'b0;
            end
        end else begin
            valid_we_s = 1'b0;
        end
    end

    // Table write port; storage needs no reset since the sweep clears it.
    always_ff @(posedge clk) begin
        if (valid_we_s) begin
            valid_q[wr_idx_s] <= valid_wdata_s;
        end
        if (tag_we_s) begin
            tag_q[wr_idx_s] <= tag_wdata_s;
        end
        if (target_we_s) begin
            target_q[wr_idx_s] <= target_wdata_s;
        end
        if (ctr_we_s) begin
            ctr_q[wr_idx_s] <= ctr_wdata_s;
        end
    end

    // Same-cycle lookup on the pre-update table contents (no bypass).
    always_comb begin
        lk_hit_s   = ready_q & valid_q[lk_idx_s] & (tag_q[lk_idx_s] == lk_tag_s);
        lk_taken_s = lk_hit_s & ctr_q[lk_idx_s][CNTBITS-1];
        if (lk_taken_s) begin
            lk_pc_s = target_q[lk_idx_s];
        end else begin
            lk_pc_s = lookup_pc + PC_STEP;
        end
    end

    assign pred_hit   = lk_hit_s;
    assign pred_taken = lk_taken_s;
    assign pred_pc    = lk_pc_s;
    assign ready      = ready_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (default parameters).
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    branch_target_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc  (lookup_pc),
        .pred_pc    (pred_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush      (flush),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic obs, input logic exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0b expected %0b", name, obs, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %08h expected %08h", name, obs, exp);
    endtask

    // Drive a lookup, queue its expected prediction, then pop and compare.
    task automatic look(input logic [31:0] pc, input logic hit, input logic taken,
                        input logic [31:0] ppc, input string name);
        exp_t e;
        exp_t got;
        e.name = name;
        e.hit = hit;
        e.taken = taken;
        e.pc = ppc;
        lookup_pc = pc;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        chk1({got.name, ".hit"}, pred_hit, got.hit);
        chk1({got.name, ".taken"}, pred_taken, got.taken);
        chk32({got.name, ".pc"}, pred_pc, got.pc);
    endtask

    // One resolved branch, applied on the next rising edge.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = taken;
        upd_target = tgt;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    // ready must stay low for 255 edges and rise after the 256th.
    task automatic wait_sweep(input string name);
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            chk1(name, ready, (i == 256));
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        upd_pc = 32'h0;
        upd_target = 32'h0;
        lookup_pc = 32'h100;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("reset_ready", ready, 1'b0);
        look(32'h100, 1'b0, 1'b0, 32'h104, "init_lookup");
        wait_sweep("sweep_after_reset");
        look(32'h100, 1'b0, 1'b0, 32'h104, "ready_miss");

        // Allocation and counter walk on 0x120
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b1, 32'h140, "alloc");
        upd(32'h120, 1'b0, 32'h0);
        look(32'h120, 1'b1, 1'b0, 32'h124, "nt_ctr1");
        upd(32'h120, 1'b0, 32'h0);
        look(32'h120, 1'b1, 1'b0, 32'h124, "nt_ctr0");
        upd(32'h120, 1'b0, 32'h0);
        look(32'h120, 1'b1, 1'b0, 32'h124, "nt_sat0");
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b0, 32'h124, "t_ctr1");
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b1, 32'h140, "t_ctr2");
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b1, 32'h140, "t_ctr3");
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b1, 32'h140, "t_sat3");

        // Aliasing: 0x520 shares index 0x48 with 0x120, different tag
        look(32'h520, 1'b0, 1'b0, 32'h524, "alias_miss");
        upd(32'h520, 1'b0, 32'h0);
        look(32'h120, 1'b1, 1'b1, 32'h140, "alias_nt_keep");
        look(32'h520, 1'b0, 1'b0, 32'h524, "alias_nt_nohit");
        upd(32'h520, 1'b1, 32'h600);
        look(32'h520, 1'b1, 1'b1, 32'h600, "alias_alloc");
        look(32'h120, 1'b0, 1'b0, 32'h124, "alias_evicted");

        // Same-cycle lookup and update: old contents this cycle, new next
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b1, 32'h140, "realloc");
        upd_valid = 1'b1;
        upd_pc = 32'h120;
        upd_taken = 1'b1;
        upd_target = 32'h180;
        look(32'h120, 1'b1, 1'b1, 32'h140, "same_cycle_old");
        @(negedge clk);
        upd_valid = 1'b0;
        look(32'h120, 1'b1, 1'b1, 32'h180, "same_cycle_new");

        // Fall-through wraps modulo 2^32
        look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, "pc_wrap");

        // Flush in READY; lookups gated during sweep; late update dropped
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk1("flush_ready_low", ready, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            chk1("flush_sweep", ready, (i == 256));
            if (i == 10) begin
                look(32'h120, 1'b0, 1'b0, 32'h124, "init_gated");
            end
            if (i == 200) begin
                upd_valid = 1'b1;
                upd_pc = 32'h200;
                upd_taken = 1'b1;
                upd_target = 32'h300;
            end else begin
                upd_valid = 1'b0;
            end
        end
        look(32'h120, 1'b0, 1'b0, 32'h124, "post_flush_0x120");
        look(32'h200, 1'b0, 1'b0, 32'h204, "init_upd_dropped");

        // Reset partway through a sweep restarts it from index 0
        upd(32'h120, 1'b1, 32'h140);
        look(32'h120, 1'b1, 1'b1, 32'h140, "pre_flush2");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
        end
        chk1("mid_sweep_ready", ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("mid_reset_ready", ready, 1'b0);
        wait_sweep("sweep_after_mid_reset");
        look(32'h120, 1'b0, 1'b0, 32'h124, "post_reset_0x120");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
